// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 (double-dabble) binary to 4-digit BCD
// converter with a start/busy/done handshake. Values above 9999 saturate the
// digits to 9999 and raise overflow. Digit outputs change only on a done pulse
// or on reset, so a downstream display never sees partial results.
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 14
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [IN_WIDTH-1:0] bin_in,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [3:0]          units,
    output logic [3:0]          tens,
    output logic [3:0]          hundreds,
    output logic [3:0]          thousands
);
    localparam int          CNT_W       = $clog2(IN_WIDTH + 1);
    localparam logic [31:0] MAX_DISPLAY = 32'd9999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    iter_cnt;
    logic [IN_WIDTH-1:0] shift_reg;
    logic [19:0]         scratch;
    logic                ovf_pend;
    logic                accept;

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift the
    // next binary bit into the LSB. Scratch is 5 digits wide, so the top nibble
    // never exceeds 6 for a 16-bit input and its carry-out can be dropped.
    function automatic logic [19:0] dabble_step(input logic [19:0] s, input logic in_bit);
        logic [15:0] lo;
        logic [2:0]  hi;
        for (int i = 0; i < 4; i++) begin
            lo[4*i +: 4] = (s[4*i +: 4] >= 4'd5) ? s[4*i +: 4] + 4'd3 : s[4*i +: 4];
        end
        hi = (s[19:16] >= 4'd5) ? s[18:16] + 3'd3 : s[18:16];
        return {hi, lo, in_bit};
    endfunction

    // True when the value cannot be shown on four decimal digits.
    function automatic logic exceeds_display(input logic [IN_WIDTH-1:0] v);
        return 32'(v) > MAX_DISPLAY;
    endfunction

    // A request is taken whenever the converter is not busy, including the
    // DONE cycle, which gives back-to-back conversions with no idle gap.
    assign accept = start && (state != CONV);

    // Control FSM and registered outputs; reset aborts any conversion in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            iter_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            units     <= 4'd0;
            tens      <= 4'd0;
            hundreds  <= 4'd0;
            thousands <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= CONV;
                        iter_cnt <= CNT_W'(IN_WIDTH);
                        busy     <= 1'b1;
                    end
                end
                CONV: begin
                    iter_cnt <= iter_cnt - CNT_W'(1);
                    if (iter_cnt == CNT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    units     <= ovf_pend ? 4'd9 : scratch[3:0];
                    tens      <= ovf_pend ? 4'd9 : scratch[7:4];
                    hundreds  <= ovf_pend ? 4'd9 : scratch[11:8];
                    thousands <= ovf_pend ? 4'd9 : scratch[15:12];
                    overflow  <= ovf_pend;
                    done      <= 1'b1;
                    if (accept) begin
                        state    <= CONV;
                        iter_cnt <= CNT_W'(IN_WIDTH);
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: latch the operand on an accepted request, iterate during CONV.
    always_ff @(posedge CLK) begin
        if (accept) begin
            shift_reg <= bin_in;
            scratch   <= 20'd0;
            ovf_pend  <= exceeds_display(bin_in);
        end else if (state == CONV) begin
            scratch   <= dabble_step(scratch, shift_reg[IN_WIDTH-1]);
            shift_reg <= {shift_reg[IN_WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: directed vector table, handshake and reset
// corner sequences, and randomized values on 14- and 16-bit builds checked
// against a divide-by-ten reference model.
module tb_bin_to_bcd_seq;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET   = 1'b1;
    logic        start_r = 1'b0;
    logic        sel     = 1'b0;   // 0: 14-bit build, 1: 16-bit build
    logic [15:0] bin_r   = 16'd0;

    logic        start14, start16;
    logic [13:0] bin14;
    logic        busy14, done14, ovf14, busy16, done16, ovf16;
    logic [3:0]  un14, te14, hu14, th14, un16, te16, hu16, th16;

    assign start14 = start_r & ~sel;
    assign start16 = start_r & sel;
    assign bin14   = bin_r[13:0];

    bin_to_bcd_seq #(.IN_WIDTH(14)) dut14 (
        .CLK(CLK), .RESET(RESET), .bin_in(bin14), .start(start14),
        .busy(busy14), .done(done14), .overflow(ovf14),
        .units(un14), .tens(te14), .hundreds(hu14), .thousands(th14)
    );

    bin_to_bcd_seq #(.IN_WIDTH(16)) dut16 (
        .CLK(CLK), .RESET(RESET), .bin_in(bin_r), .start(start16),
        .busy(busy16), .done(done16), .overflow(ovf16),
        .units(un16), .tens(te16), .hundreds(hu16), .thousands(th16)
    );

    logic        cur_busy, cur_done, cur_ovf;
    logic [15:0] cur_digits;
    assign cur_busy   = sel ? busy16 : busy14;
    assign cur_done   = sel ? done16 : done14;
    assign cur_ovf    = sel ? ovf16  : ovf14;
    assign cur_digits = sel ? {th16, hu16, te16, un16} : {th14, hu14, te14, un14};

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int unsigned val;
        logic [15:0] bcd;   // thousands..units as hex nibbles
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain decimal digit extraction with saturation at 9999.
    function automatic logic [16:0] model(input int unsigned v);
        if (v > 9999) return {1'b1, 16'h9999};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Issue one accepted start and wait for done; returns at the done cycle.
    task automatic run_conv(input int unsigned v, output int lat, output int busy_n);
        @(negedge CLK);
        bin_r   = 16'(v);
        start_r = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start_r = 1'b0;
        bin_r   = 16'($urandom);
        lat     = 0;
        busy_n  = 0;
        while (!cur_done && lat < 40) begin
            if (cur_busy) busy_n++;
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
    endtask

    initial begin
        int          lat, bn, dn, gap, exp_lat, nhold;
        int unsigned v;
        logic [16:0] exp;
        logic [15:0] got;

        vecs[0]  = '{1234,  16'h1234, 1'b0};
        vecs[1]  = '{0,     16'h0000, 1'b0};
        vecs[2]  = '{9999,  16'h9999, 1'b0};
        vecs[3]  = '{10000, 16'h9999, 1'b1};
        vecs[4]  = '{16383, 16'h9999, 1'b1};
        vecs[5]  = '{42,    16'h0042, 1'b0};
        vecs[6]  = '{1,     16'h0001, 1'b0};
        vecs[7]  = '{10,    16'h0010, 1'b0};
        vecs[8]  = '{100,   16'h0100, 1'b0};
        vecs[9]  = '{1000,  16'h1000, 1'b0};
        vecs[10] = '{9990,  16'h9990, 1'b0};
        vecs[11] = '{5,     16'h0005, 1'b0};

        // T1: reset held 3 cycles with start asserted; reset must win
        RESET   = 1'b1;
        start_r = 1'b1;
        bin_r   = 16'd1234;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET   = 1'b0;
        start_r = 1'b0;
        check("rst_busy14", 32'(busy14), 0);
        check("rst_done14", 32'(done14), 0);
        check("rst_ovf14", 32'(ovf14), 0);
        check("rst_digits14", 32'({th14, hu14, te14, un14}), 0);
        check("rst_busy16", 32'(busy16), 0);
        check("rst_digits16", 32'({th16, hu16, te16, un16}), 0);
        @(negedge CLK);
        check("rst_no_start", 32'(busy14), 0);

        // T2/T3: table of directed values on the 14-bit build
        sel = 1'b0;
        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i].val, lat, bn);
            check($sformatf("vec%0d_latency", i), 32'(lat), 15);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bn), 14);
            check($sformatf("vec%0d_digits", i), 32'(cur_digits), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_ovf", i), 32'(cur_ovf), 32'(vecs[i].ovf));
            @(negedge CLK);
            check($sformatf("vec%0d_done_pulse", i), 32'(cur_done), 0);
        end

        // T4a: start during CONV is ignored and bin_in is not resampled
        @(negedge CLK);
        bin_r   = 16'd1234;
        start_r = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start_r = 1'b0;
        repeat (5) @(negedge CLK);
        check("hs_busy_mid", 32'(cur_busy), 1);
        bin_r   = 16'd5678;
        start_r = 1'b1;
        @(negedge CLK);
        start_r = 1'b0;
        bin_r   = 16'd0;
        dn  = 0;
        got = 16'h0;
        repeat (40) begin
            @(negedge CLK);
            if (cur_done) begin
                dn++;
                got = cur_digits;
            end
        end
        check("hs_single_done", 32'(dn), 1);
        check("hs_ignored_digits", 32'(got), 32'h1234);

        // T4b: start on the done cycle gives the next done 16 cycles later
        run_conv(1234, lat, bn);
        check("b2b_first_digits", 32'(cur_digits), 32'h1234);
        bin_r   = 16'd5678;
        start_r = 1'b1;
        gap     = 0;
        do begin
            @(posedge CLK);
            gap++;
            @(negedge CLK);
            start_r = 1'b0;
            bin_r   = 16'($urandom);
        end while (!cur_done && gap < 40);
        check("b2b_gap", 32'(gap), 16);
        check("b2b_digits", 32'(cur_digits), 32'h5678);

        // T5: reset mid-conversion aborts without a done pulse
        @(negedge CLK);
        bin_r   = 16'd777;
        start_r = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start_r = 1'b0;
        repeat (4) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort_busy", 32'(cur_busy), 0);
        check("abort_digits", 32'(cur_digits), 0);
        dn = 0;
        repeat (30) begin
            @(negedge CLK);
            if (cur_done) dn++;
        end
        check("abort_no_done", 32'(dn), 0);
        check("abort_digits_hold", 32'(cur_digits), 0);
        run_conv(777, lat, bn);
        check("after_abort_latency", 32'(lat), 15);
        check("after_abort_digits", 32'(cur_digits), 32'h0777);

        // T6: random values on both builds, with digit hold between dones
        for (int s = 0; s < 2; s++) begin
            sel     = (s == 1);
            exp_lat = (s == 1) ? 17 : 15;
            for (int i = 0; i < 100; i++) begin
                if (i % 4 == 0) v = 9995 + $urandom_range(0, 10);
                else if (s == 1) v = $urandom_range(0, 65535);
                else v = $urandom_range(0, 16383);
                exp = model(v);
                run_conv(v, lat, bn);
                check($sformatf("rnd%0d_%0d_latency", s, v), 32'(lat), 32'(exp_lat));
                check($sformatf("rnd%0d_%0d_digits", s, v), 32'(cur_digits), 32'(exp[15:0]));
                check($sformatf("rnd%0d_%0d_ovf", s, v), 32'(cur_ovf), 32'(exp[16]));
                nhold = $urandom_range(1, 4);
                repeat (nhold) begin
                    @(negedge CLK);
                    bin_r = 16'($urandom);
                end
                check($sformatf("rnd%0d_%0d_hold", s, v), 32'(cur_digits), 32'(exp[15:0]));
                check($sformatf("rnd%0d_%0d_hold_ovf", s, v), 32'(cur_ovf), 32'(exp[16]));
                check($sformatf("rnd%0d_%0d_no_done", s, v), 32'(cur_done), 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
